// File: rtl/alu_op_sequencer_if.sv
// Command channel between the switch/command front end and the ALU op sequencer.
// The front end is the master and offers one command per valid/ready handshake.
interface alu_op_sequencer_if #(
    parameter int CNT_W = 4
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [2:0]       cmd_op;
    logic [4:0]       cmd_ra;
    logic [4:0]       cmd_rb;
    logic [4:0]       cmd_rw;
    logic [CNT_W-1:0] cmd_cnt;
    logic             abort;

    modport master (
        output cmd_valid, cmd_op, cmd_ra, cmd_rb, cmd_rw, cmd_cnt, abort,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_ra, cmd_rb, cmd_rw, cmd_cnt, abort,
        output cmd_ready
    );
endinterface

// File: rtl/alu_op_sequencer.sv
// Micro-sequencer driving the register-file/ALU datapath: each accepted command runs
// N read/write-back iterations, feeding the destination back as operand A.
module alu_op_sequencer #(
    parameter int CNT_W = 4
) (
    input  logic                clk,
    input  logic                reset,
    alu_op_sequencer_if.slave   cmd,
    output logic [4:0]          R_Addr_A,
    output logic [4:0]          R_Addr_B,
    output logic [4:0]          W_Addr,
    output logic                Write_Reg,
    output logic [2:0]          ALU_OP,
    input  logic [31:0]         alu_f,
    input  logic                alu_zf,
    input  logic                alu_of,
    output logic                busy,
    output logic                done,
    output logic                aborted,
    output logic [31:0]         res_f,
    output logic                res_zf,
    output logic                of_sticky
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        WB   = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t           state;
    state_t           next_state;
    logic [CNT_W-1:0] remaining;
    logic             abort_pend;
    logic             abort_now;
    logic             last_iter;
    logic             wb_stop;

    // An abort seen during READ is remembered so it still ends the command at the next WB.
    assign abort_now = cmd.abort || abort_pend;
    assign last_iter = (remaining == CNT_W'(1));
    assign wb_stop   = abort_now || last_iter;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state    = state;
        cmd.cmd_ready = 1'b0;
        Write_Reg     = 1'b0;
        busy          = 1'b0;
        done          = 1'b0;
        case (state)
            IDLE: begin
                cmd.cmd_ready = 1'b1;
                if (cmd.cmd_valid) begin
                    next_state = READ;
                end
            end
            READ: begin
                busy       = 1'b1;
                next_state = WB;
            end
            WB: begin
                busy       = 1'b1;
                Write_Reg  = 1'b1;
                next_state = wb_stop ? DONE : READ;
            end
            DONE: begin
                done       = 1'b1;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // Addresses are loaded on entry to READ so they are stable across READ and WB;
    // the captured command itself lives in W_Addr, R_Addr_B and ALU_OP.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            R_Addr_A   <= 5'd0;
            R_Addr_B   <= 5'd0;
            W_Addr     <= 5'd0;
            ALU_OP     <= 3'd0;
            remaining  <= '0;
            abort_pend <= 1'b0;
            aborted    <= 1'b0;
            res_f      <= 32'd0;
            res_zf     <= 1'b0;
            of_sticky  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd.cmd_valid) begin
                        R_Addr_A   <= cmd.cmd_ra;
                        R_Addr_B   <= cmd.cmd_rb;
                        W_Addr     <= cmd.cmd_rw;
                        ALU_OP     <= cmd.cmd_op;
                        remaining  <= (cmd.cmd_cnt == '0) ? CNT_W'(1) : cmd.cmd_cnt;
                        abort_pend <= 1'b0;
                        aborted    <= 1'b0;
                        of_sticky  <= 1'b0;
                    end
                end
                READ: begin
                    if (cmd.abort) begin
                        abort_pend <= 1'b1;
                    end
                end
                WB: begin
                    res_f      <= alu_f;
                    res_zf     <= alu_zf;
                    of_sticky  <= of_sticky | alu_of;
                    remaining  <= remaining - CNT_W'(1);
                    abort_pend <= 1'b0;
                    if (wb_stop) begin
                        aborted <= abort_now && !last_iter;
                    end else begin
                        R_Addr_A <= W_Addr;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Self-checking bench: register file + ALU environment around the sequencer, with an
// iteration-level reference model driven by directed and randomized commands.
module tb_alu_op_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  R_Addr_A, R_Addr_B, W_Addr;
    logic        Write_Reg;
    logic [2:0]  ALU_OP;
    logic [31:0] alu_f;
    logic        alu_zf, alu_of;
    logic        busy, done, aborted;
    logic [31:0] res_f;
    logic        res_zf, of_sticky;

    logic [31:0] env_regs [32];
    logic [31:0] ref_regs [32];
    logic        mem_load;
    logic [32:0] alu_res;
    int          n_compared = 0;
    int          n_mismatched = 0;

    alu_op_sequencer_if #(.CNT_W(4)) cmd_bus ();

    alu_op_sequencer #(.CNT_W(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .cmd       (cmd_bus.slave),
        .R_Addr_A  (R_Addr_A),
        .R_Addr_B  (R_Addr_B),
        .W_Addr    (W_Addr),
        .Write_Reg (Write_Reg),
        .ALU_OP    (ALU_OP),
        .alu_f     (alu_f),
        .alu_zf    (alu_zf),
        .alu_of    (alu_of),
        .busy      (busy),
        .done      (done),
        .aborted   (aborted),
        .res_f     (res_f),
        .res_zf    (res_zf),
        .of_sticky (of_sticky)
    );

    always #5 clk = ~clk;

    function automatic logic [32:0] alu_eval(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] f;
        logic        of;
        of = 1'b0;
        case (op)
            3'b000: f = a & b;
            3'b001: f = a | b;
            3'b010: f = a ^ b;
            3'b011: f = ~(a | b);
            3'b100: begin f = a + b; of = (a[31] == b[31]) && (f[31] != a[31]); end
            3'b101: begin f = a - b; of = (a[31] != b[31]) && (f[31] != a[31]); end
            3'b110: f = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            default: f = a << b[4:0];
        endcase
        return {of, f};
    endfunction

    function automatic logic [31:0] init_reg(input int i);
        if (i == 0) return 32'h00010001;
        if (i == 1) return 32'h00100010;
        return 32'd0;
    endfunction

    // Register file: R0 ignores writes but keeps its power-up contents.
    always @(posedge clk) begin
        if (mem_load) begin
            for (int i = 0; i < 32; i++) env_regs[i] <= init_reg(i);
        end else if (Write_Reg && W_Addr != 5'd0) begin
            env_regs[W_Addr] <= alu_f;
        end
    end

    always_comb alu_res = alu_eval(ALU_OP, env_regs[R_Addr_A], env_regs[R_Addr_B]);
    assign alu_f  = alu_res[31:0];
    assign alu_of = alu_res[32];
    assign alu_zf = (alu_res[31:0] == 32'd0);

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_compared++;
        if (obs !== exp) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: run whole iterations on the model register file.
    task automatic run_model(input logic [2:0] op, input logic [4:0] ra, input logic [4:0] rb,
                             input logic [4:0] rw, input int iters,
                             output logic [31:0] f, output logic zf, output logic of);
        logic [32:0] r;
        f = 32'd0; zf = 1'b0; of = 1'b0;
        for (int k = 0; k < iters; k++) begin
            r  = alu_eval(op, (k == 0) ? ref_regs[ra] : ref_regs[rw], ref_regs[rb]);
            f  = r[31:0];
            zf = (r[31:0] == 32'd0);
            of = of | r[32];
            if (rw != 5'd0) ref_regs[rw] = r[31:0];
        end
    endtask

    task automatic apply_stimulus(input logic [2:0] op, input logic [4:0] ra, input logic [4:0] rb,
                                  input logic [4:0] rw, input logic [3:0] cnt,
                                  input int abort_at, input int reset_at);
        int          n, iters, cyc, writes, done_cyc;
        bit          exp_aborted, finished, seen_done;
        logic [31:0] ef;
        logic        ezf, eof;

        n = (cnt == 4'd0) ? 1 : int'(cnt);
        if (reset_at > 0)                            iters = (reset_at - 1) / 2;
        else if (abort_at >= 1 && abort_at <= 2 * n) iters = (abort_at + 1) / 2;
        else                                         iters = n;
        exp_aborted = (reset_at == 0) && (iters < n);
        run_model(op, ra, rb, rw, iters, ef, ezf, eof);

        check_output("ready_before_accept", {31'd0, cmd_bus.cmd_ready}, 32'd1);
        cmd_bus.cmd_op = op; cmd_bus.cmd_ra = ra; cmd_bus.cmd_rb = rb;
        cmd_bus.cmd_rw = rw; cmd_bus.cmd_cnt = cnt; cmd_bus.cmd_valid = 1'b1;
        @(posedge clk); #1;

        writes = 0; done_cyc = -1; finished = 1'b0;
        for (cyc = 1; cyc <= 40 && !finished; cyc++) begin
            cmd_bus.abort = (cyc == abort_at);
            if (cyc == reset_at) begin
                check_output("wb_before_reset", {31'd0, Write_Reg}, {31'd0, reset_at % 2 == 0});
                cmd_bus.cmd_valid = 1'b0;
                reset = 1'b1;
                #1;
                check_output("wr_async_drop", {31'd0, Write_Reg}, 32'd0);
                check_output("ready_after_reset", {31'd0, cmd_bus.cmd_ready}, 32'd1);
                check_output("busy_after_reset", {31'd0, busy}, 32'd0);
                finished = 1'b1;
            end else begin
                if (Write_Reg) writes++;
                if (done) begin
                    done_cyc = cyc;
                    finished = 1'b1;
                    cmd_bus.cmd_valid = 1'b0;
                end else begin
                    // Junk commands while busy must be ignored.
                    cmd_bus.cmd_valid = 1'($urandom_range(0, 1));
                    cmd_bus.cmd_op = 3'($urandom); cmd_bus.cmd_ra = 5'($urandom);
                    cmd_bus.cmd_rb = 5'($urandom); cmd_bus.cmd_rw = 5'($urandom);
                    cmd_bus.cmd_cnt = 4'($urandom);
                    @(posedge clk); #1;
                end
            end
        end
        cmd_bus.abort = 1'b0;
        cmd_bus.cmd_valid = 1'b0;

        if (reset_at > 0) begin
            @(posedge clk); #1;
            reset = 1'b0;
            seen_done = 1'b0;
            repeat (3) begin
                @(posedge clk); #1;
                seen_done = seen_done | done;
            end
            check_output("no_done_after_reset", {31'd0, seen_done}, 32'd0);
            check_output("res_f_after_reset", res_f, 32'd0);
            check_output("alu_op_after_reset", {29'd0, ALU_OP}, 32'd0);
            check_output("reg_after_reset", env_regs[rw], ref_regs[rw]);
        end else begin
            check_output("done_cycle", done_cyc, 2 * iters + 1);
            check_output("write_count", writes, iters);
            check_output("res_f", res_f, ef);
            check_output("res_zf", {31'd0, res_zf}, {31'd0, ezf});
            check_output("of_sticky", {31'd0, of_sticky}, {31'd0, eof});
            check_output("aborted", {31'd0, aborted}, {31'd0, exp_aborted});
            check_output("reg_rw", env_regs[rw], ref_regs[rw]);
            check_output("reg_r0", env_regs[0], ref_regs[0]);
            @(posedge clk); #1;
            check_output("done_one_cycle", {31'd0, done}, 32'd0);
            check_output("ready_returns", {31'd0, cmd_bus.cmd_ready}, 32'd1);
        end
    endtask

    initial begin
        int          n, ab;
        logic [3:0]  cnt;

        reset = 1'b1; mem_load = 1'b1;
        cmd_bus.cmd_valid = 1'b0; cmd_bus.abort = 1'b0;
        cmd_bus.cmd_op = 3'd0; cmd_bus.cmd_ra = 5'd0; cmd_bus.cmd_rb = 5'd0;
        cmd_bus.cmd_rw = 5'd0; cmd_bus.cmd_cnt = 4'd0;
        for (int i = 0; i < 32; i++) ref_regs[i] = init_reg(i);
        repeat (2) @(posedge clk);
        #1;
        mem_load = 1'b0;
        reset = 1'b0;
        @(posedge clk); #1;

        check_output("rst_ready", {31'd0, cmd_bus.cmd_ready}, 32'd1);
        check_output("rst_busy", {31'd0, busy}, 32'd0);
        check_output("rst_done", {31'd0, done}, 32'd0);
        check_output("rst_write", {31'd0, Write_Reg}, 32'd0);
        check_output("rst_res_f", res_f, 32'd0);
        check_output("rst_alu_op", {29'd0, ALU_OP}, 32'd0);
        check_output("rst_addrs", {17'd0, R_Addr_A, R_Addr_B, W_Addr}, 32'd0);

        apply_stimulus(3'b100, 5'd0, 5'd1, 5'd2, 4'd1, 0, 0);
        check_output("r2_value", env_regs[2], 32'h00110011);
        apply_stimulus(3'b100, 5'd0, 5'd1, 5'd3, 4'd3, 0, 0);
        check_output("r3_value", env_regs[3], 32'h00310031);
        apply_stimulus(3'b010, 5'd1, 5'd1, 5'd4, 4'd0, 0, 0);
        check_output("r4_zero", env_regs[4], 32'd0);
        check_output("r4_zf", {31'd0, res_zf}, 32'd1);
        apply_stimulus(3'b100, 5'd0, 5'd1, 5'd5, 4'd5, 3, 0);
        check_output("r5_value", env_regs[5], 32'h00210021);
        check_output("r5_aborted", {31'd0, aborted}, 32'd1);
        apply_stimulus(3'b100, 5'd0, 5'd1, 5'd0, 4'd2, 0, 0);
        check_output("r0_kept", env_regs[0], 32'h00010001);
        apply_stimulus(3'b100, 5'd1, 5'd1, 5'd6, 4'd4, 0, 4);
        check_output("r6_one_write", env_regs[6], 32'h00200020);

        for (int t = 0; t < 60; t++) begin
            cnt = 4'($urandom_range(0, 15));
            n   = (cnt == 4'd0) ? 1 : int'(cnt);
            ab  = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 2 * n + 1)) : 0;
            apply_stimulus(3'($urandom), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                           5'($urandom_range(0, 7)), cnt, ab, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule

// File: doc/alu_op_sequencer.md
Name: alu_op_sequencer

Overview:
Micro-sequencer that owns the register-file/ALU datapath. It accepts one command per valid/ready handshake: opcode, source A, source B, destination and repeat count. It then drives the register-file read/write addresses, the 3-bit ALU opcode and the write strobe so the result is written back, repeating N times with the destination fed back as operand A. The block sits between the switch/command front end and the Register_file + ALU pair. It reports the final F, ZF, a sticky OF, and a one-cycle done pulse.

Parameters:
CNT_W, 4, width of repeat-count field; a command performs max(cmd_cnt,1) iterations.

Ports:
clk  in  1  system clock, all state on rising edge
reset  in  1  asynchronous, active-high reset
cmd_valid  in  1  command present
cmd_ready  out  1  sequencer can accept a command (IDLE only)
cmd_op  in  3  ALU opcode: 000 and, 001 or, 010 xor, 011 nor, 100 add, 101 sub, 110 slt, 111 shl
cmd_ra  in  5  first-iteration operand A register
cmd_rb  in  5  operand B register, all iterations
cmd_rw  in  5  destination register
cmd_cnt  in  CNT_W  iteration count; 0 is treated as 1
abort  in  1  stop after the current write-back
R_Addr_A  out  5  register-file read address A
R_Addr_B  out  5  register-file read address B
W_Addr  out  5  register-file write address
Write_Reg  out  1  register-file write enable; W_Data is the ALU F output
ALU_OP  out  3  ALU opcode
alu_f  in  32  ALU result F
alu_zf  in  1  ALU zero flag
alu_of  in  1  ALU overflow flag
busy  out  1  high in READ and WB
done  out  1  one-cycle pulse in DONE
aborted  out  1  last command terminated by abort; valid from DONE until next accept
res_f  out  32  F captured at last write-back
res_zf  out  1  ZF captured at last write-back
of_sticky  out  1  OR of alu_of over all write-backs of the current command

Behaviour:
- Clock and reset: one clock. Reset is asynchronous and active-high. Reset forces IDLE, clears all outputs and registers to 0, then sets cmd_ready=1.
- States: IDLE, READ, WB, DONE.
- IDLE:
  - cmd_ready=1, Write_Reg=0.
  - On a rising edge with cmd_valid=1, capture op/ra/rb/rw.
  - Load remaining = (cmd_cnt==0) ? 1 : cmd_cnt.
  - Clear of_sticky and aborted, set first=1, go to READ.
- READ (settle cycle):
  - R_Addr_A = first ? ra : rw; R_Addr_B = rb; W_Addr = rw; ALU_OP = op. All are registered and stable through the following WB.
  - Write_Reg=0. Go to WB.
- WB:
  - Write_Reg=1 for exactly this cycle; addresses and opcode unchanged. The register file writes alu_f at the closing edge.
  - At the same edge: res_f<=alu_f, res_zf<=alu_zf, of_sticky<=of_sticky|alu_of, remaining<=remaining-1, first<=0.
  - If abort=1 or remaining==1, go to DONE (aborted<=abort && remaining!=1). Otherwise go to READ.
- DONE: done=1, Write_Reg=0, cmd_ready=0. Go to IDLE next cycle.
- Latency: accept edge at cycle 0; READ/WB pairs occupy cycles 1..2N; done is high in cycle 2N+1; cmd_ready returns in cycle 2N+2.
- Feedback: iteration k>1 reads rw after the iteration k-1 write has landed, with no bypass needed. The A operand is rw, the B operand is rb.
- rw==0: Write_Reg is still pulsed; the register file ignores the write. Sequencing, res_* and done behave normally, and later iterations read the unchanged R0.
- abort: ignored in IDLE and DONE. In READ it takes effect at the following WB; that write still completes and no further write occurs.
- cmd_valid while not IDLE: ignored, no capture.
- Reset mid-command: Write_Reg drops immediately (asynchronously); no done pulse.
- ALU_OP and addresses hold their last values in IDLE/DONE.

Test Plan:
1. Reset asserted, then released -> cmd_ready=1, busy=0, done=0, Write_Reg=0, res_f=0, ALU_OP=0, all addresses 0. The bench resets the sequencer only, so the register file keeps its power-up contents R0=0x00010001, R1=0x00100010.
2. Add: op=100, ra=0, rb=1, rw=2, cnt=1 -> Write_Reg high in cycle 2 only, done in cycle 3, R2=0x00110011, res_zf=0, of_sticky=0.
3. Repeated add: op=100, ra=0, rb=1, rw=3, cnt=3 -> R3 takes 0x00110011, then 0x00210021, then 0x00310031; 3 write pulses; done in cycle 7; res_f=0x00310031.
4. XOR to zero: op=010, ra=1, rb=1, rw=4, cnt=0 -> one iteration; R4=0, res_zf=1.
5. Abort: op=100, ra=0, rb=1, rw=5, cnt=5, abort pulsed in the second READ -> exactly 2 writes, R5=0x00210021, done high, aborted=1.
6. Write to R0 and reset mid-command: first a command with rw=0 -> done pulses and R0 stays 0x00010001. Then issue cnt=4 and assert reset during WB -> Write_Reg falls without waiting for an edge, state returns to IDLE, no done pulse.
